// File: rtl/karatsuba_gf2_seq.sv
// Two-way Karatsuba carry-less multiplier: three half-width partial products are
// scheduled through one bit-serial shift-and-XOR engine, then combined into c.
module karatsuba_gf2_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; a source holds its data until then, and ready never waits on valid.
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] c,
  output logic           busy,
  output logic [1:0]     phase,
  output logic [2:0]     state_dbg
);

  localparam int L  = W / 2;
  localparam int H  = W - L;
  localparam int PW = 2 * H - 1;
  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(H - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL_LO  = 3'd1,
    S_MUL_HI  = 3'd2,
    S_MUL_MID = 3'd3,
    S_COMBINE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [PW-1:0] mcand;
  logic [H-1:0]  mplier;
  logic [PW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [PW-1:0] p_lo;
  logic [PW-1:0] p_hi;
  logic [PW-1:0] p_mm;

  logic [PW-1:0]  acc_next;
  logic           job_last;
  logic [2*W-1:0] c_next;

  function automatic logic [H-1:0] low_half(input logic [W-1:0] v);
    low_half = '0;
    low_half[L-1:0] = v[L-1:0];
  endfunction

  function automatic logic [H-1:0] high_half(input logic [W-1:0] v);
    high_half = v[W-1:L];
  endfunction

  function automatic logic [PW-1:0] widen(input logic [H-1:0] v);
    widen = '0;
    widen[H-1:0] = v;
  endfunction

  // The multiplicand register is pre-shifted every cycle, so bit i of the
  // multiplier always lines up with multiplicand << i.
  assign acc_next = acc ^ (mplier[0] ? mcand : '0);
  assign job_last = (cnt == CNT_LAST);

  always_comb begin
    logic [2*W-1:0] ext_lo;
    logic [2*W-1:0] ext_hi;
    logic [2*W-1:0] ext_mid;
    ext_lo  = '0;
    ext_hi  = '0;
    ext_mid = '0;
    ext_lo[PW-1:0]  = p_lo;
    ext_hi[PW-1:0]  = p_hi;
    ext_mid[PW-1:0] = p_mm ^ p_hi ^ p_lo;
    c_next = (ext_hi << (2 * L)) ^ (ext_mid << L) ^ ext_lo;
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      p_lo      <= '0;
      p_hi      <= '0;
      p_mm      <= '0;
      c         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      phase     <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            mcand    <= widen(low_half(a));
            mplier   <= low_half(b);
            acc      <= '0;
            cnt      <= '0;
            state    <= S_MUL_LO;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            phase    <= 2'd1;
          end
        end

        S_MUL_LO, S_MUL_HI, S_MUL_MID: begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          acc    <= acc_next;
          cnt    <= cnt + 1'b1;
          if (job_last) begin
            acc <= '0;
            cnt <= '0;
            case (state)
              S_MUL_LO: begin
                p_lo   <= acc_next;
                mcand  <= widen(high_half(a_reg));
                mplier <= high_half(b_reg);
                state  <= S_MUL_HI;
                phase  <= 2'd2;
              end
              S_MUL_HI: begin
                p_hi   <= acc_next;
                mcand  <= widen(high_half(a_reg) ^ low_half(a_reg));
                mplier <= high_half(b_reg) ^ low_half(b_reg);
                state  <= S_MUL_MID;
                phase  <= 2'd3;
              end
              default: begin
                p_mm  <= acc_next;
                state <= S_COMBINE;
                phase <= 2'd0;
              end
            endcase
          end
        end

        S_COMBINE: begin
          c         <= c_next;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          phase     <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/karatsuba_gf2_seq.md
# karatsuba_gf2_seq

Sequential controller for a two-way Karatsuba carry-less (GF(2)[x]) multiplier built around one shared bit-serial shift-and-XOR engine. It accepts a W-bit operand pair over a valid/ready handshake and splits each operand into halves. It schedules the three half-width partial products (low, high, middle) through the single engine, then combines them into the 2W-bit polynomial product. It sits between the field-arithmetic front end and the reduction stage, trading latency for one multiplier core instead of three.

## Interface
- W, default 16: operand width; legal range W >= 4. Derived values: L = floor(W/2) (low-half width) and H = W - L (high-half and engine width).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  W  operand A, polynomial, bit i = coefficient of x^i.
- b  in  W  operand B, same encoding.
- out_valid  out  1  product c valid.
- out_ready  in  1  downstream accepts c.
- c  out  2W  carry-less product; bit 2W-1 is always 0.
- busy  out  1  high in every state except IDLE.
- phase  out  2  current engine job: 0 = none/combine, 1 = LO, 2 = HI, 3 = MID.

## Operation
- Input transfer happens when in_valid & in_ready at a rising edge. The block captures a and b into internal registers, so the inputs may change afterwards.
- Operand split: al = a[L-1:0], ah = a[W-1:L]; bl and bh are split the same way. Zero-extend al and bl to H bits.
- FSM states: IDLE, MUL_LO, MUL_HI, MUL_MID, COMBINE, DONE.
- Transitions:
  - IDLE goes to MUL_LO on transfer.
  - Each MUL_* state lasts exactly H cycles, then advances to the next: LO, then HI, then MID, then COMBINE.
  - COMBINE goes to DONE after 1 cycle.
  - DONE goes to IDLE when out_ready is high.
- Engine, one H-bit job per MUL state:
  - On entry, load the multiplicand (H bits) and the multiplier shift register (H bits), clear a (2H-1)-bit accumulator, and clear the bit counter i.
  - Each cycle: if the multiplier LSB is 1, acc ^= multiplicand << i. Then shift the multiplier right and increment i.
  - The job ends when i = H-1 has been processed. No early termination on zero operands.
- Job operands:
  - LO: al × bl, stored into p_lo.
  - HI: ah × bh, stored into p_hi.
  - MID: (ah ^ al) × (bh ^ bl), stored into p_mm.
- Arithmetic is XOR only; there are no carries or borrows anywhere.
- COMBINE:
  - mid = p_mm ^ p_hi ^ p_lo.
  - c_reg = (p_hi << 2L) ^ (mid << L) ^ p_lo, truncated to 2W bits. The bits above 2W-2 are provably zero.
- DONE: out_valid = 1 and c is held stable until the cycle where out_ready is high.
- phase encodes the current MUL state; it is 0 in IDLE, COMBINE and DONE.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, phase=0, c=0; FSM in IDLE; all internal registers cleared.
- Reset mid-operation (any state) aborts the job. Outputs show reset values from the next cycle, and no partial result is ever presented.
- Latency from the transfer edge to out_valid rising is exactly 3H+1 cycles. For W=16 this is 25 cycles.
- in_ready is low from the cycle after the transfer edge until the cycle after the output handshake. A new transfer is possible 1 cycle after out_valid & out_ready.
- out_ready held low: the block stays in DONE indefinitely, and c and out_valid are stable.
- in_valid asserted while busy is ignored, with no side effects and no queueing.
- out_ready may be high before DONE; it has no effect until DONE.
- c changes only in COMBINE and on reset.

## Test plan
- W=16, a=0x0003, b=0x0003, out_ready=1 → out_valid exactly 25 cycles after transfer, c=0x00000005.
- W=16, a=0x8000, b=0x8000 → c=0x40000000. W=16, a=0xFFFF, b=0x0001 → c=0x0000FFFF.
- W=16, a=0x0000, b=0xABCD → c=0 after the full 25 cycles (no early exit). Then back-to-back: a second transfer is accepted 1 cycle after the first output handshake.
- Backpressure: a=0x1234, b=0x5678, out_ready held low for 10 cycles after DONE → c remains 0x05C58160 and out_valid stays 1. in_valid pulses during this window are ignored.
- Reset asserted in MUL_HI (cycle 12 after transfer) → next cycle in_ready=1, busy=0, out_valid=0, c=0. A following job with a=0x0003, b=0x0003 returns 0x00000005.
- W=17 and W=521: 1000 random pairs each, compared against a bit-serial carry-less reference model. Latency must equal 3·9+1=28 (W=17) and 3·261+1=784 (W=521).
